// File: rtl/div_ctrl_pkg.sv
// Shared widths, handshake levels and controller state encoding for the EX-stage
// divider requester.
package div_ctrl_pkg;

  localparam int unsigned RegBus       = 32;
  localparam int unsigned DoubleRegBus = 64;

  localparam logic [RegBus-1:0] ZeroWord = '0;

  localparam logic DivStart       = 1'b1;
  localparam logic DivStop        = 1'b0;
  localparam logic DivResultReady = 1'b1;

  typedef enum logic [1:0] {
    DivCtrlIdle  = 2'b00,
    DivCtrlBusy  = 2'b01,
    DivCtrlDone  = 2'b10,
    DivCtrlAbort = 2'b11
  } div_ctrl_state_e;

endpackage

// File: rtl/div_ctrl.sv
// Requester side of the multi-cycle divider handshake: latches operands, holds the
// pipeline while the divider runs, and presents the result as a single HI/LO write.
module div_ctrl
  import div_ctrl_pkg::*;
(
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    div_req_i,
  input  logic                    div_signed_i,
  input  logic [RegBus-1:0]       op1_i,
  input  logic [RegBus-1:0]       op2_i,
  input  logic                    flush_i,
  input  logic                    ex_stall_i,
  input  logic                    div_ready_i,
  input  logic [DoubleRegBus-1:0] div_result_i,
  output logic                    div_start_o,
  output logic                    div_annul_o,
  output logic                    div_signed_o,
  output logic [RegBus-1:0]       div_opdata1_o,
  output logic [RegBus-1:0]       div_opdata2_o,
  output logic                    stallreq_o,
  output logic                    whilo_o,
  output logic [RegBus-1:0]       hi_o,
  output logic [RegBus-1:0]       lo_o
);

  div_ctrl_state_e   state_q, state_d;
  logic [RegBus-1:0] op1_q, op2_q;
  logic              signed_q;
  logic [RegBus-1:0] hi_q, lo_q;
  logic              latch_ops;
  logic              capture;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= DivCtrlIdle;
      op1_q    <= ZeroWord;
      op2_q    <= ZeroWord;
      signed_q <= 1'b0;
      hi_q     <= ZeroWord;
      lo_q     <= ZeroWord;
    end else begin
      state_q <= state_d;
      if (latch_ops) begin
        op1_q    <= op1_i;
        op2_q    <= op2_i;
        signed_q <= div_signed_i;
      end
      if (capture) begin
        hi_q <= div_result_i[DoubleRegBus-1:RegBus];
        lo_q <= div_result_i[RegBus-1:0];
      end
    end
  end

  always_comb begin
    state_d     = state_q;
    latch_ops   = 1'b0;
    capture     = 1'b0;
    div_start_o = DivStop;
    div_annul_o = 1'b0;
    stallreq_o  = 1'b0;
    whilo_o     = 1'b0;
    hi_o        = ZeroWord;
    lo_o        = ZeroWord;
    case (state_q)
      DivCtrlIdle: begin
        // Gated by rst so every output reads 0 while reset is asserted.
        stallreq_o = div_req_i & ~flush_i & ~rst;
        if (div_req_i && !flush_i) begin
          latch_ops = 1'b1;
          state_d   = DivCtrlBusy;
        end
      end
      DivCtrlBusy: begin
        stallreq_o = 1'b1;
        if (flush_i) begin
          // A ready arriving with the flush is dropped; the divider is annulled.
          div_annul_o = 1'b1;
          state_d     = DivCtrlAbort;
        end else begin
          div_start_o = DivStart;
          if (div_ready_i == DivResultReady) begin
            capture = 1'b1;
            state_d = DivCtrlDone;
          end
        end
      end
      DivCtrlDone: begin
        hi_o    = hi_q;
        lo_o    = lo_q;
        whilo_o = ~flush_i;
        if (!ex_stall_i || flush_i) begin
          state_d = DivCtrlIdle;
        end
      end
      DivCtrlAbort: begin
        // One quiet cycle lets a divider parked in its end state return to free.
        stallreq_o = div_req_i;
        state_d    = DivCtrlIdle;
      end
      default: begin
        state_d = DivCtrlIdle;
      end
    endcase
  end

  assign div_signed_o  = signed_q;
  assign div_opdata1_o = op1_q;
  assign div_opdata2_o = op2_q;

endmodule

// File: tb/tb_div_ctrl.sv
// Directed and randomized checks of div_ctrl against a behavioural divider and
// arithmetic reference for quotient/remainder and handshake timing.
module tb_div_ctrl;

  logic        clk;
  logic        rst;
  logic        div_req;
  logic        div_signed;
  logic [31:0] op1;
  logic [31:0] op2;
  logic        flush;
  logic        ex_stall;
  logic        div_ready;
  logic [63:0] div_result;
  logic        div_start_o;
  logic        div_annul_o;
  logic        div_signed_o;
  logic [31:0] div_opdata1_o;
  logic [31:0] div_opdata2_o;
  logic        stallreq_o;
  logic        whilo_o;
  logic [31:0] hi_o;
  logic [31:0] lo_o;

  int passed = 0;
  int total  = 0;
  int fails  = 0;

  div_ctrl dut (
    .clk          (clk),
    .rst          (rst),
    .div_req_i    (div_req),
    .div_signed_i (div_signed),
    .op1_i        (op1),
    .op2_i        (op2),
    .flush_i      (flush),
    .ex_stall_i   (ex_stall),
    .div_ready_i  (div_ready),
    .div_result_i (div_result),
    .div_start_o  (div_start_o),
    .div_annul_o  (div_annul_o),
    .div_signed_o (div_signed_o),
    .div_opdata1_o(div_opdata1_o),
    .div_opdata2_o(div_opdata2_o),
    .stallreq_o   (stallreq_o),
    .whilo_o      (whilo_o),
    .hi_o         (hi_o),
    .lo_o         (lo_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Quotient truncates toward zero, remainder takes the dividend's sign; /0 gives {0,0}.
  function automatic logic [63:0] ref_div(input logic [31:0] a, input logic [31:0] b,
                                          input logic s);
    longint x, y, q, r;
    if (b == 32'd0) return 64'd0;
    if (s) begin
      x = longint'($signed(a));
      y = longint'($signed(b));
    end else begin
      x = longint'({32'd0, a});
      y = longint'({32'd0, b});
    end
    q = x / y;
    r = x % y;
    return {r[31:0], q[31:0]};
  endfunction

  // Divider model: ready on the 36th start cycle (4th for a zero divisor), held until
  // start drops.
  int dv_cnt;
  always @(posedge clk or posedge rst) begin
    if (rst) dv_cnt <= 0;
    else if (div_start_o && !div_annul_o) dv_cnt <= dv_cnt + 1;
    else dv_cnt <= 0;
  end
  assign div_ready  = div_start_o && !div_annul_o &&
                      (dv_cnt >= ((div_opdata2_o == 32'd0) ? 3 : 35));
  assign div_result = div_ready ? ref_div(div_opdata1_o, div_opdata2_o, div_signed_o) : 64'd0;

  int   start_rises = 0;
  int   annul_cnt   = 0;
  int   whilo_cnt   = 0;
  logic prev_start  = 1'b0;
  always @(posedge clk) begin
    prev_start <= div_start_o;
    if (div_start_o && !prev_start) start_rises <= start_rises + 1;
    if (div_annul_o) annul_cnt <= annul_cnt + 1;
    if (whilo_o) whilo_cnt <= whilo_cnt + 1;
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic run_div(input logic [31:0] a, input logic [31:0] b, input logic s,
                         input int stall_n, input logic [31:0] exp_hi,
                         input logic [31:0] exp_lo);
    int done_c;
    int rises0;
    bit busy_ok;
    bit done_ok;
    done_c = (b == 32'd0) ? 5 : 37;
    rises0 = start_rises;
    next_cycle();
    div_req = 1'b1; div_signed = s; op1 = a; op2 = b; flush = 1'b0; ex_stall = 1'b0;
    #1;
    check("c0_stallreq", 64'(stallreq_o), 64'd1);
    check("c0_start", 64'(div_start_o), 64'd0);
    busy_ok = 1'b1;
    for (int c = 1; c < done_c; c++) begin
      next_cycle();
      // Scramble the live inputs: the divider must only see the latched copies.
      op1 = $urandom; op2 = $urandom; div_signed = 1'($urandom_range(0, 1));
      #1;
      if (!(stallreq_o && div_start_o && !whilo_o && !div_annul_o &&
            div_opdata1_o == a && div_opdata2_o == b && div_signed_o == s))
        busy_ok = 1'b0;
    end
    check("busy_window", 64'(busy_ok), 64'd1);
    next_cycle();
    ex_stall = (stall_n > 0);
    #1;
    check("done_whilo", 64'(whilo_o), 64'd1);
    check("done_hi", 64'(hi_o), 64'(exp_hi));
    check("done_lo", 64'(lo_o), 64'(exp_lo));
    check("done_ctl", 64'({div_start_o, stallreq_o}), 64'd0);
    done_ok = 1'b1;
    for (int i = 0; i < stall_n; i++) begin
      next_cycle();
      ex_stall = (i < stall_n - 1);
      #1;
      if (!(whilo_o && !div_start_o && !stallreq_o && hi_o == exp_hi && lo_o == exp_lo))
        done_ok = 1'b0;
    end
    if (stall_n > 0) check("done_held", 64'(done_ok), 64'd1);
    next_cycle();
    div_req = 1'b0; ex_stall = 1'b0;
    #1;
    check("post_idle", 64'({whilo_o, div_start_o, stallreq_o}), 64'd0);
    check("post_hilo", {hi_o, lo_o}, 64'd0);
    check("one_start", 64'(start_rises - rises0), 64'd1);
  endtask

  initial begin
    logic [31:0] ra, rb;
    logic        rs;
    logic [63:0] rexp;
    int          a0, w0;

    rst = 1'b1; div_req = 1'b0; div_signed = 1'b0; op1 = '0; op2 = '0;
    flush = 1'b0; ex_stall = 1'b0;
    #12;
    check("rst_ctl", 64'({div_start_o, div_annul_o, stallreq_o, whilo_o, div_signed_o}), 64'd0);
    check("rst_ops", {div_opdata1_o, div_opdata2_o}, 64'd0);
    check("rst_hilo", {hi_o, lo_o}, 64'd0);
    rst = 1'b0;

    run_div(32'd100, 32'd7, 1'b0, 0, 32'd2, 32'd14);
    run_div(32'hFFFF_FFF9, 32'd2, 1'b1, 0, 32'hFFFF_FFFF, 32'hFFFF_FFFD);
    run_div(32'hFFFF_FFF9, 32'd2, 1'b0, 0, 32'd1, 32'h7FFF_FFFC);
    run_div(32'd5, 32'd0, 1'b0, 0, 32'd0, 32'd0);
    run_div(32'd77, 32'd10, 1'b0, 3, 32'd7, 32'd7);

    // Flush in IDLE: no stall, no latch.
    next_cycle();
    div_req = 1'b1; flush = 1'b1; op1 = 32'd6; op2 = 32'd2;
    #1;
    check("idle_flush_stall", 64'(stallreq_o), 64'd0);
    next_cycle();
    div_req = 1'b0; flush = 1'b0;
    #1;
    check("idle_flush_nostart", 64'(div_start_o), 64'd0);

    // Flush in BUSY cycle 10, then 9 / 3 from the IDLE cycle right after ABORT.
    a0 = annul_cnt; w0 = whilo_cnt;
    next_cycle();
    div_req = 1'b1; div_signed = 1'b0; op1 = 32'd1000; op2 = 32'd3;
    for (int c = 1; c < 10; c++) next_cycle();
    next_cycle();
    flush = 1'b1;
    #1;
    check("flush_annul", 64'(div_annul_o), 64'd1);
    check("flush_start", 64'(div_start_o), 64'd0);
    check("flush_whilo", 64'(whilo_o), 64'd0);
    next_cycle();
    flush = 1'b0; div_req = 1'b1; op1 = 32'd9; op2 = 32'd3;
    #1;
    check("abort_ctl", 64'({div_annul_o, div_start_o, whilo_o}), 64'd0);
    check("abort_stallreq", 64'(stallreq_o), 64'd1);
    run_div(32'd9, 32'd3, 1'b0, 0, 32'd0, 32'd3);
    check("flush_one_annul", 64'(annul_cnt - a0), 64'd1);
    check("flush_one_write", 64'(whilo_cnt - w0), 64'd1);

    // Asynchronous reset in the middle of BUSY.
    next_cycle();
    div_req = 1'b1; div_signed = 1'b1; op1 = 32'd50; op2 = 32'd5;
    for (int c = 0; c < 6; c++) next_cycle();
    #3;
    rst = 1'b1;
    #1;
    check("arst_ctl", 64'({div_start_o, div_annul_o, stallreq_o, whilo_o, div_signed_o}), 64'd0);
    check("arst_ops", {div_opdata1_o, div_opdata2_o}, 64'd0);
    check("arst_hilo", {hi_o, lo_o}, 64'd0);
    #1;
    rst = 1'b0; div_req = 1'b0;
    run_div(32'd8, 32'd2, 1'b0, 0, 32'd0, 32'd4);

    for (int n = 0; n < 8; n++) begin
      ra = $urandom;
      case ($urandom_range(0, 3))
        0:       rb = 32'd0;
        1:       rb = $urandom_range(1, 100);
        default: rb = $urandom;
      endcase
      rs   = 1'($urandom_range(0, 1));
      rexp = ref_div(ra, rb, rs);
      run_div(ra, rb, rs, $urandom_range(0, 2), rexp[63:32], rexp[31:0]);
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
